// File: rtl/ahb_pkg.sv
// Shared AHB encodings and SPLIT-controller state definitions.
package ahb_pkg;

  localparam int unsigned NUM_MASTERS_DEF = 16;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPLIT1 = 3'd1,
    ST_SPLIT2 = 3'd2,
    ST_RETRY1 = 3'd3,
    ST_RETRY2 = 3'd4
  } split_state_t;

endpackage

// File: rtl/ahb_split_fifo.sv
// Synchronous FIFO of split master IDs, released in arrival order.
module ahb_split_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ahb_split_ctrl.sv
// Slave-side SPLIT controller: two-cycle SPLIT/RETRY responses and ordered HSPLIT release.
module ahb_split_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int unsigned MID_W       = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  input  logic [MID_W-1:0]       HMASTER,
  input  logic                   HMASTLOCK,
  input  logic                   RES_BUSY,
  output logic                   HREADYOUT,
  output logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HSPLIT,
  output logic [MID_W:0]         SPLIT_CNT
);

  split_state_t           state;
  split_state_t           state_next;
  hresp_t                 resp_next;
  logic                   ready_next;
  logic [NUM_MASTERS-1:0] mask;
  logic [NUM_MASTERS-1:0] mask_next;
  logic [MID_W:0]         cnt_next;
  logic                   accept;
  logic                   can_accept;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [MID_W-1:0]       head;

  assign accept = HSEL && HREADY &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  // First response cycle holds HREADYOUT low, so no new address phase completes there.
  assign can_accept = (state == ST_IDLE) || (state == ST_SPLIT2) || (state == ST_RETRY2);
  assign pop = !RES_BUSY && !fifo_empty;

  always_comb begin
    state_next = state;
    push       = 1'b0;
    ready_next = 1'b1;
    resp_next  = HRESP_OKAY;
    case (state)
      ST_SPLIT1: state_next = ST_SPLIT2;
      ST_RETRY1: state_next = ST_RETRY2;
      default:   state_next = ST_IDLE;
    endcase
    // Locked transfers and already-split masters are answered RETRY, never queued twice.
    if (can_accept && accept && RES_BUSY) begin
      if (!HMASTLOCK && !mask[HMASTER]) begin
        state_next = ST_SPLIT1;
        push       = 1'b1;
      end else begin
        state_next = ST_RETRY1;
      end
    end
    case (state_next)
      ST_SPLIT1: begin ready_next = 1'b0; resp_next = HRESP_SPLIT; end
      ST_SPLIT2: begin ready_next = 1'b1; resp_next = HRESP_SPLIT; end
      ST_RETRY1: begin ready_next = 1'b0; resp_next = HRESP_RETRY; end
      ST_RETRY2: begin ready_next = 1'b1; resp_next = HRESP_RETRY; end
      default:   begin ready_next = 1'b1; resp_next = HRESP_OKAY;  end
    endcase
  end

  always_comb begin
    mask_next = mask;
    if (pop)  mask_next[head]    = 1'b0;
    if (push) mask_next[HMASTER] = 1'b1;
    cnt_next = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cnt_next = cnt_next + (MID_W + 1)'(mask_next[i]);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      mask      <= '0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      HSPLIT    <= '0;
      SPLIT_CNT <= '0;
    end else begin
      state     <= state_next;
      mask      <= mask_next;
      HREADYOUT <= ready_next;
      HRESP     <= resp_next;
      HSPLIT    <= pop ? (NUM_MASTERS'(1) << head) : '0;
      SPLIT_CNT <= cnt_next;
    end
  end

  ahb_split_fifo #(
    .DEPTH (NUM_MASTERS),
    .W     (MID_W)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push),
    .pop   (pop),
    .din   (HMASTER),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // The mask keeps IDs unique, so the queue can never overflow.
  assert property (@(posedge HCLK) disable iff (HRESET) !(push && fifo_full));

endmodule

// File: tb/tb_ahb_split_ctrl.sv
// Directed bench for ahb_split_ctrl: responses, ordered release, locked/duplicate, reset.
module tb_ahb_split_ctrl;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [3:0]  HMASTER;
  logic        HMASTLOCK;
  logic        RES_BUSY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [15:0] HSPLIT;
  logic [4:0]  SPLIT_CNT;

  int vectors;
  int miscompares;

  ahb_split_ctrl dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK),
    .RES_BUSY  (RES_BUSY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HSPLIT    (HSPLIT),
    .SPLIT_CNT (SPLIT_CNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic rdy, input logic [1:0] rsp,
                           input logic [15:0] spl, input logic [4:0] cnt);
    check({tag, ".hreadyout"}, 32'(HREADYOUT), 32'(rdy));
    check({tag, ".hresp"},     32'(HRESP),     32'(rsp));
    check({tag, ".hsplit"},    32'(HSPLIT),    32'(spl));
    check({tag, ".split_cnt"}, 32'(SPLIT_CNT), 32'(cnt));
  endtask

  // Issue one NONSEQ from a master, then two idle bus cycles.
  task automatic issue(input logic [3:0] mid);
    HSEL = 1'b1; HTRANS = 2'b10; HMASTER = mid;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    HRESET = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
    HMASTER = '0; HMASTLOCK = 1'b0; RES_BUSY = 1'b0;

    // Reset with busy core and active select
    HRESET = 1'b1; RES_BUSY = 1'b1; HSEL = 1'b1; HTRANS = 2'b10;
    tick(); tick();
    check_rsp("reset", 1'b1, 2'b00, 16'h0000, 5'd0);
    HRESET = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; RES_BUSY = 1'b0;
    tick();

    // Not busy: zero-wait OKAY
    HSEL = 1'b1; HTRANS = 2'b10; HMASTER = 4'd3;
    tick();
    check_rsp("notbusy", 1'b1, 2'b00, 16'h0000, 5'd0);
    HSEL = 1'b0; HTRANS = 2'b00;
    tick();
    check_rsp("notbusy_after", 1'b1, 2'b00, 16'h0000, 5'd0);

    // Busy: split master 5, then release
    RES_BUSY = 1'b1; HSEL = 1'b1; HTRANS = 2'b10; HMASTER = 4'd5;
    tick();
    check_rsp("split5_c1", 1'b0, 2'b11, 16'h0000, 5'd1);
    HSEL = 1'b0; HTRANS = 2'b00;
    tick();
    check_rsp("split5_c2", 1'b1, 2'b11, 16'h0000, 5'd1);
    tick();
    check_rsp("split5_idle", 1'b1, 2'b00, 16'h0000, 5'd1);
    RES_BUSY = 1'b0;
    tick();
    check_rsp("rel5", 1'b1, 2'b00, 16'h0020, 5'd0);
    tick();
    check_rsp("rel5_after", 1'b1, 2'b00, 16'h0000, 5'd0);

    // Ordering 9, 2, 14; master 2 arrives during the second SPLIT cycle of 9
    RES_BUSY = 1'b1; HSEL = 1'b1; HTRANS = 2'b10; HMASTER = 4'd9;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    tick();
    check_rsp("split9_c2", 1'b1, 2'b11, 16'h0000, 5'd1);
    HSEL = 1'b1; HTRANS = 2'b11; HMASTER = 4'd2;
    tick();
    check_rsp("split2_b2b", 1'b0, 2'b11, 16'h0000, 5'd2);
    HSEL = 1'b0; HTRANS = 2'b00;
    tick(); tick();
    issue(4'd14);
    check_rsp("three_split", 1'b1, 2'b00, 16'h0000, 5'd3);
    RES_BUSY = 1'b0;
    tick();
    check_rsp("rel_9", 1'b1, 2'b00, 16'h0200, 5'd2);
    tick();
    check_rsp("rel_2", 1'b1, 2'b00, 16'h0004, 5'd1);
    tick();
    check_rsp("rel_14", 1'b1, 2'b00, 16'h4000, 5'd0);
    tick();
    check_rsp("rel_done", 1'b1, 2'b00, 16'h0000, 5'd0);

    // Locked transfer while busy: RETRY, nothing queued
    RES_BUSY = 1'b1; HSEL = 1'b1; HTRANS = 2'b10; HMASTER = 4'd7; HMASTLOCK = 1'b1;
    tick();
    check_rsp("lock_c1", 1'b0, 2'b10, 16'h0000, 5'd0);
    HSEL = 1'b0; HTRANS = 2'b00; HMASTLOCK = 1'b0;
    tick();
    check_rsp("lock_c2", 1'b1, 2'b10, 16'h0000, 5'd0);
    tick();
    check_rsp("lock_idle", 1'b1, 2'b00, 16'h0000, 5'd0);

    // Duplicate ID: second request from 9 gets RETRY, single release only
    issue(4'd9);
    check_rsp("dup_first", 1'b1, 2'b00, 16'h0000, 5'd1);
    HSEL = 1'b1; HTRANS = 2'b10; HMASTER = 4'd9;
    tick();
    check_rsp("dup_c1", 1'b0, 2'b10, 16'h0000, 5'd1);
    HSEL = 1'b0; HTRANS = 2'b00;
    tick();
    check_rsp("dup_c2", 1'b1, 2'b10, 16'h0000, 5'd1);
    tick();
    RES_BUSY = 1'b0;
    tick();
    check_rsp("dup_rel", 1'b1, 2'b00, 16'h0200, 5'd0);
    tick();
    check_rsp("dup_norel1", 1'b1, 2'b00, 16'h0000, 5'd0);
    tick();
    check_rsp("dup_norel2", 1'b1, 2'b00, 16'h0000, 5'd0);

    // Non-transfer HTRANS and HREADY low are ignored even while busy
    RES_BUSY = 1'b1; HSEL = 1'b1; HTRANS = 2'b01; HMASTER = 4'd6;
    tick();
    check_rsp("htrans_busy", 1'b1, 2'b00, 16'h0000, 5'd0);
    HTRANS = 2'b10; HREADY = 1'b0;
    tick();
    check_rsp("hready_low", 1'b1, 2'b00, 16'h0000, 5'd0);
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1;
    tick();

    // Reset with three splits pending: no release pulse afterwards
    issue(4'd1);
    issue(4'd4);
    issue(4'd11);
    check_rsp("pre_reset", 1'b1, 2'b00, 16'h0000, 5'd3);
    HRESET = 1'b1; RES_BUSY = 1'b0;
    tick();
    check_rsp("mid_reset", 1'b1, 2'b00, 16'h0000, 5'd0);
    HRESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_rsp("post_reset", 1'b1, 2'b00, 16'h0000, 5'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
